ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipelined MIPS core. It sits directly downstream of the ID/EX pipeline register and consumes its operand and control outputs. It resolves data hazards by forwarding from EX/MEM and MEM/WB, and computes ALU results. It runs an iterative 32-cycle multiply/divide unit with HI/LO registers, stalling upstream stages while that unit is busy, and it contains the EX/MEM pipeline register.

## Interface
- REG_AW, 4, register-specifier width (16 GPRs, r0 hardwired zero)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd1ID, rd2ID, extID  in  32 each  ID/EX operands and sign-extended immediate
- ID_EXRs, ID_EXRt, ID_EXRd  in  REG_AW each  ID/EX register specifiers
- MemReadID, MemtoRegID, MemWriteID, ALUSrcID, RegWriteID  in  1 each  ID/EX control
- ALUopID  in  2  00 add, 01 sub, 10 R-type (funct = extID[5:0]), 11 or
- wb_regwrite  in  1;  wb_rd  in  REG_AW;  wb_data  in  32  MEM/WB writeback forwarding source
- ex_mem_alu_result  out  32  registered ALU/mfhi/mflo result
- ex_mem_wdata  out  32  registered forwarded rt value (store data)
- ex_mem_rd  out  REG_AW  registered destination register
- ex_mem_zero  out  1  registered (ALU result == 0)
- ex_mem_memread, ex_mem_memtoreg, ex_mem_memwrite, ex_mem_regwrite  out  1 each  registered control
- ex_stall  out  1  combinational; PC, IF/ID and ID/EX must hold while high

## Operation
- Forwarding for operand A (rs) and operand B (rt):
  - EX/MEM is forwarded if ex_mem_regwrite && !ex_mem_memtoreg && ex_mem_rd != 0 && ex_mem_rd == specifier.
  - Otherwise MEM/WB is forwarded if wb_regwrite && wb_rd != 0 && wb_rd == specifier.
  - Otherwise the ID/EX value is used.
  - EX/MEM has priority over MEM/WB.
  - Load-use bubbles are inserted upstream, not here.
- ALU B input = ALUSrcID ? extID : forwarded rt.
- Destination = ALUSrcID ? ID_EXRt : ID_EXRd.
- R-type funct codes:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed)
  - 0x00 sll and 0x02 srl: shift rt by extID[10:6]
  - 0x10 mfhi, 0x12 mflo
  - 0x19 multu, 0x1B divu
  - Any other funct produces result 0.
- Arithmetic is 32-bit wrap-around with no overflow trap.
- multu: HI:LO = 64-bit unsigned product (shift-add).
- divu: LO = quotient, HI = remainder (restoring). Divisor 0 gives LO = 0xFFFFFFFF, HI = dividend.
- Mult/div FSM states:
  - IDLE: multu/divu present in EX, so capture forwarded operands, count=0, go to BUSY.
  - BUSY: one iteration per cycle. When count==31, write HI/LO and go to DONE.
  - DONE: the held instruction advances as a no-op, go to IDLE.
- ex_stall = (IDLE && multu/divu in EX) || BUSY.
- While ex_stall=1, EX/MEM loads a bubble: all four control outputs = 0, data fields don't-care but driven 0.
- HI/LO change only at the end of the final BUSY iteration.

## Timing
- ALU path latency: 1 cycle, from ID/EX values to EX/MEM outputs on the next clk edge.
- multu/divu: ex_stall is high for exactly 33 cycles (entry cycle plus 32 BUSY), then low in DONE. A following mfhi/mflo enters EX after DONE and sees the new HI/LO.
- Reset (asynchronous, immediate, including mid-BUSY):
  - All EX/MEM outputs = 0.
  - HI = LO = 0, FSM = IDLE, count = 0.
  - ex_stall = 0 within the reset cycle.
- Forwarding uses the current-cycle EX/MEM and MEM/WB values; there is no register-file bypass here.

## Structure
- Shared package ex_pkg holds:
  - ALUop encodings
  - funct constants
  - internal ALU-operation enum
  - md FSM state enum (IDLE, BUSY, DONE)
- Sub-module md_unit holds:
  - the iterative multiply/divide datapath
  - HI/LO registers, the counter and the FSM
  - interface: start, op, a, b → busy, hi, lo
- Forwarding muxes, ALU, ALU control decode and the EX/MEM register live in ex_stage.

## Test plan
- Basic ALU: R-type add, rd1ID=5, rd2ID=7, Rd=3 → next edge result=12, ex_mem_rd=3, regwrite=1, zero=0.
- EX/MEM forwarding: add r3=5+7, then sub r4=r3-r1 with stale rd1ID=0 → result 7. The same pair separated by one bubble, with wb_rd=3, wb_data=12, takes the MEM/WB path → result 7. wb_rd=0 is never forwarded.
- Branch compare: ALUop=01, rd1=rd2=9 → zero=1.
- Load address: ALUop=00, ALUSrc=1, rd1=0x100, ext=0xFFFFFFFC → result 0xFC, ex_mem_rd=Rt, memread=1.
- Multiply: multu 0xFFFFFFFF×2 → ex_stall high 33 cycles with bubbles in EX/MEM, HI=1, LO=0xFFFFFFFE. A following mfhi → result 1.
- Divide: divu 100/7 → LO=14, HI=2. divu 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234.
- Reset mid-op: rst at BUSY count=10 → ex_stall=0 and outputs 0 without waiting for clk, HI=LO=0. A fresh multu after reset completes correctly.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALUop and funct codes,
// the internal ALU operation set and the multiply/divide FSM states.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;

  localparam logic MD_OP_MULTU = 1'b0;
  localparam logic MD_OP_DIVU  = 1'b1;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_MFHI,
    ALU_MFLO,
    ALU_MULTU,
    ALU_DIVU,
    ALU_NONE
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  function automatic logic isMdOp(input alu_op_e op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_md_unit.sv
// Iterative 32-cycle unsigned multiply (shift-add) / divide (restoring)
// unit owning the HI/LO registers.
module md_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  md_state_e   r_state;
  logic [4:0]  r_count;
  logic        r_op;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [32:0] w_mulSum;
  logic [32:0] w_divShift;
  logic [32:0] w_divTrial;
  logic [63:0] w_next;

  // r_acc holds {partial product, multiplier} for multu and
  // {remainder, dividend/quotient} for divu; both shift one bit per cycle.
  always_comb begin
    w_mulSum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    w_divShift = {r_acc[63:32], r_acc[31]};
    w_divTrial = w_divShift - {1'b0, r_b};
    w_next     = {w_mulSum, r_acc[31:1]};
    if (r_op == MD_OP_DIVU) begin
      if (w_divTrial[32]) begin
        w_next = {w_divShift[31:0], r_acc[30:0], 1'b0};
      end else begin
        w_next = {w_divTrial[31:0], r_acc[30:0], 1'b1};
      end
    end
  end

  // A zero divisor needs no special case: every trial subtract succeeds,
  // giving an all-ones quotient and the dividend as remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_count <= 5'd0;
      r_op    <= MD_OP_MULTU;
      r_b     <= 32'd0;
      r_acc   <= 64'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state <= MD_BUSY;
            r_count <= 5'd0;
            r_op    <= i_op;
            r_b     <= i_b;
            r_acc   <= {32'd0, i_a};
          end
        end
        MD_BUSY: begin
          r_acc   <= w_next;
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_hi    <= w_next[63:32];
            r_lo    <= w_next[31:0];
            r_state <= MD_DONE;
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_busy = !rst && (((r_state == MD_IDLE) && i_start) || (r_state == MD_BUSY));
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and its control decode, the
// multiply/divide unit hookup and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rd1ID,
  input  logic [31:0]       rd2ID,
  input  logic [31:0]       extID,
  input  logic [REG_AW-1:0] ID_EXRs,
  input  logic [REG_AW-1:0] ID_EXRt,
  input  logic [REG_AW-1:0] ID_EXRd,
  input  logic              MemReadID,
  input  logic              MemtoRegID,
  input  logic              MemWriteID,
  input  logic              ALUSrcID,
  input  logic              RegWriteID,
  input  logic [1:0]        ALUopID,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [31:0]       wb_data,
  output logic [31:0]       ex_mem_alu_result,
  output logic [31:0]       ex_mem_wdata,
  output logic [REG_AW-1:0] ex_mem_rd,
  output logic              ex_mem_zero,
  output logic              ex_mem_memread,
  output logic              ex_mem_memtoreg,
  output logic              ex_mem_memwrite,
  output logic              ex_mem_regwrite,
  output logic              ex_stall
);

  logic [31:0] w_fwdA;
  logic [31:0] w_fwdB;
  logic [31:0] w_aluB;
  logic [31:0] w_result;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic        w_isMd;
  logic        w_bubble;
  logic        w_mdBusy;
  alu_op_e     w_aluOp;

  // Loads in EX/MEM have no data yet; those hazards are bubbled upstream.
  function automatic logic [31:0] forward(input logic [REG_AW-1:0] spec,
                                          input logic [31:0]       idVal);
    if (ex_mem_regwrite && !ex_mem_memtoreg && (ex_mem_rd != '0) && (ex_mem_rd == spec))
      return ex_mem_alu_result;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == spec))
      return wb_data;
    else
      return idVal;
  endfunction

  always_comb begin
    w_fwdA = forward(ID_EXRs, rd1ID);
    w_fwdB = forward(ID_EXRt, rd2ID);
    w_aluB = ALUSrcID ? extID : w_fwdB;
  end

  always_comb begin
    w_aluOp = ALU_NONE;
    case (ALUopID)
      ALUOP_ADD: w_aluOp = ALU_ADD;
      ALUOP_SUB: w_aluOp = ALU_SUB;
      ALUOP_OR:  w_aluOp = ALU_OR;
      ALUOP_RTYPE: begin
        case (extID[5:0])
          FUNCT_ADD:   w_aluOp = ALU_ADD;
          FUNCT_SUB:   w_aluOp = ALU_SUB;
          FUNCT_AND:   w_aluOp = ALU_AND;
          FUNCT_OR:    w_aluOp = ALU_OR;
          FUNCT_SLT:   w_aluOp = ALU_SLT;
          FUNCT_SLL:   w_aluOp = ALU_SLL;
          FUNCT_SRL:   w_aluOp = ALU_SRL;
          FUNCT_MFHI:  w_aluOp = ALU_MFHI;
          FUNCT_MFLO:  w_aluOp = ALU_MFLO;
          FUNCT_MULTU: w_aluOp = ALU_MULTU;
          FUNCT_DIVU:  w_aluOp = ALU_DIVU;
          default:     w_aluOp = ALU_NONE;
        endcase
      end
      default: w_aluOp = ALU_NONE;
    endcase
  end

  always_comb begin
    w_result = 32'd0;
    case (w_aluOp)
      ALU_ADD:  w_result = w_fwdA + w_aluB;
      ALU_SUB:  w_result = w_fwdA - w_aluB;
      ALU_AND:  w_result = w_fwdA & w_aluB;
      ALU_OR:   w_result = w_fwdA | w_aluB;
      ALU_SLT:  w_result = {31'd0, $signed(w_fwdA) < $signed(w_aluB)};
      ALU_SLL:  w_result = w_fwdB << extID[10:6];
      ALU_SRL:  w_result = w_fwdB >> extID[10:6];
      ALU_MFHI: w_result = w_hi;
      ALU_MFLO: w_result = w_lo;
      default:  w_result = 32'd0;
    endcase
  end

  assign w_isMd = isMdOp(w_aluOp);

  md_unit u_md (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_isMd),
    .i_op    ((w_aluOp == ALU_DIVU) ? MD_OP_DIVU : MD_OP_MULTU),
    .i_a     (w_fwdA),
    .i_b     (w_fwdB),
    .o_busy  (w_mdBusy),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  assign ex_stall = w_mdBusy;

  // multu/divu never write a GPR, so they leave EX as a bubble even in DONE.
  assign w_bubble = ex_stall || w_isMd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_bubble) begin
      ex_mem_alu_result <= 32'd0;
      ex_mem_wdata      <= 32'd0;
      ex_mem_rd         <= '0;
      ex_mem_zero       <= 1'b0;
      ex_mem_memread    <= 1'b0;
      ex_mem_memtoreg   <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
      ex_mem_regwrite   <= 1'b0;
    end else begin
      ex_mem_alu_result <= w_result;
      ex_mem_wdata      <= w_fwdB;
      ex_mem_rd         <= ALUSrcID ? ID_EXRt : ID_EXRd;
      ex_mem_zero       <= (w_result == 32'd0);
      ex_mem_memread    <= MemReadID;
      ex_mem_memtoreg   <= MemtoRegID;
      ex_mem_memwrite   <= MemWriteID;
      ex_mem_regwrite   <= RegWriteID;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage: ALU ops, forwarding paths,
// multu/divu stall timing with HI/LO readback, and asynchronous reset.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int REG_AW = 4;
  localparam logic [4:0] CTL_NONE = 5'b00000;
  localparam logic [4:0] CTL_R    = 5'b00001;
  localparam logic [4:0] CTL_IMM  = 5'b10001;
  localparam logic [4:0] CTL_LW   = 5'b11101;

  logic              clk;
  logic              rst;
  logic [31:0]       rd1ID, rd2ID, extID;
  logic [REG_AW-1:0] ID_EXRs, ID_EXRt, ID_EXRd;
  logic              MemReadID, MemtoRegID, MemWriteID, ALUSrcID, RegWriteID;
  logic [1:0]        ALUopID;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic [31:0]       wb_data;
  logic [31:0]       ex_mem_alu_result, ex_mem_wdata;
  logic [REG_AW-1:0] ex_mem_rd;
  logic              ex_mem_zero, ex_mem_memread, ex_mem_memtoreg;
  logic              ex_mem_memwrite, ex_mem_regwrite, ex_stall;

  ex_stage #(.REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .rd1ID(rd1ID), .rd2ID(rd2ID), .extID(extID),
    .ID_EXRs(ID_EXRs), .ID_EXRt(ID_EXRt), .ID_EXRd(ID_EXRd),
    .MemReadID(MemReadID), .MemtoRegID(MemtoRegID), .MemWriteID(MemWriteID),
    .ALUSrcID(ALUSrcID), .RegWriteID(RegWriteID), .ALUopID(ALUopID),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_wdata(ex_mem_wdata),
    .ex_mem_rd(ex_mem_rd), .ex_mem_zero(ex_mem_zero),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memtoreg(ex_mem_memtoreg),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_regwrite(ex_mem_regwrite),
    .ex_stall(ex_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic [3:0]  rd;
    logic        zero;
    logic [3:0]  ctl;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ext, input logic [3:0] rs, input logic [3:0] rt,
                               input logic [3:0] rd, input logic [4:0] ctl);
    ALUopID = op; rd1ID = a; rd2ID = b; extID = ext;
    ID_EXRs = rs; ID_EXRt = rt; ID_EXRd = rd;
    {ALUSrcID, MemReadID, MemtoRegID, MemWriteID, RegWriteID} = ctl;
  endtask

  task automatic setWb(input logic rw, input logic [3:0] rd, input logic [31:0] data);
    wb_regwrite = rw; wb_rd = rd; wb_data = data;
  endtask

  task automatic expectOut(input string tag, input logic [31:0] result, input logic [3:0] rd,
                           input logic zero, input logic [3:0] ctl);
    exp_t e;
    e.tag = tag; e.result = result; e.rd = rd; e.zero = zero; e.ctl = ctl;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = scoreboard.pop_front();
      checkEq({e.tag, ".result"}, ex_mem_alu_result, e.result);
      checkEq({e.tag, ".rd"}, 32'(ex_mem_rd), 32'(e.rd));
      checkEq({e.tag, ".zero"}, 32'(ex_mem_zero), 32'(e.zero));
      checkEq({e.tag, ".ctl"},
              32'({ex_mem_memread, ex_mem_memtoreg, ex_mem_memwrite, ex_mem_regwrite}), 32'(e.ctl));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Issues multu/divu, measures the stall window and the bubbles it leaves,
  // then reads HI and LO back with mfhi/mflo against a native-arithmetic model.
  task automatic runMd(input string tag, input logic isDiv, input logic [31:0] a, input logic [31:0] b);
    int          stalls;
    logic        bubbleOk;
    logic [63:0] model;
    if (isDiv) model = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    else       model = {32'd0, a} * {32'd0, b};
    applyStimulus(ALUOP_RTYPE, a, b, 32'(isDiv ? FUNCT_DIVU : FUNCT_MULTU), 4'd1, 4'd2, 4'd0, CTL_R);
    #1;
    stalls   = 0;
    bubbleOk = 1'b1;
    while (ex_stall === 1'b1 && stalls < 100) begin
      stalls++;
      @(posedge clk);
      #1;
      if (ex_mem_regwrite !== 1'b0 || ex_mem_memwrite !== 1'b0 || ex_mem_alu_result !== 32'd0)
        bubbleOk = 1'b0;
    end
    checkEq({tag, ".stall_cycles"}, 32'(stalls), 32'd33);
    checkEq({tag, ".stall_bubbles"}, 32'(bubbleOk), 32'd1);
    expectOut({tag, ".noop"}, 32'd0, 4'd0, 1'b0, 4'b0000);
    step();
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'd0, 32'(FUNCT_MFHI), 4'd0, 4'd0, 4'd14, CTL_R);
    expectOut({tag, ".mfhi"}, model[63:32], 4'd14, model[63:32] == 32'd0, 4'b0001);
    step();
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'd0, 32'(FUNCT_MFLO), 4'd0, 4'd0, 4'd15, CTL_R);
    expectOut({tag, ".mflo"}, model[31:0], 4'd15, model[31:0] == 32'd0, 4'b0001);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    setWb(1'b0, 4'd0, 32'd0);
    applyStimulus(ALUOP_RTYPE, 32'd5, 32'd7, 32'(FUNCT_ADD), 4'd1, 4'd2, 4'd3, CTL_R);
    @(posedge clk);
    #1;
    checkEq("reset.result", ex_mem_alu_result, 32'd0);
    checkEq("reset.ctl", 32'({ex_mem_rd, ex_mem_zero, ex_mem_memread, ex_mem_memtoreg,
                              ex_mem_memwrite, ex_mem_regwrite}), 32'd0);
    applyStimulus(ALUOP_RTYPE, 32'd3, 32'd4, 32'(FUNCT_MULTU), 4'd1, 4'd2, 4'd0, CTL_R);
    #1;
    checkEq("reset.stall", 32'(ex_stall), 32'd0);
    applyStimulus(ALUOP_ADD, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, CTL_NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(ALUOP_RTYPE, 32'd5, 32'd7, 32'(FUNCT_ADD), 4'd1, 4'd2, 4'd3, CTL_R);
    expectOut("add", 32'd12, 4'd3, 1'b0, 4'b0001);
    step();
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'd5, 32'(FUNCT_SUB), 4'd3, 4'd1, 4'd4, CTL_R);
    expectOut("fwd_exmem", 32'd7, 4'd4, 1'b0, 4'b0001);
    step();
    setWb(1'b1, 4'd4, 32'd99);
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'd0, 32'(FUNCT_ADD), 4'd4, 4'd0, 4'd5, CTL_R);
    expectOut("fwd_priority", 32'd7, 4'd5, 1'b0, 4'b0001);
    step();
    setWb(1'b0, 4'd0, 32'd0);
    applyStimulus(ALUOP_RTYPE, 32'd5, 32'd7, 32'(FUNCT_ADD), 4'd1, 4'd2, 4'd3, CTL_R);
    expectOut("add2", 32'd12, 4'd3, 1'b0, 4'b0001);
    step();
    applyStimulus(ALUOP_ADD, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, CTL_NONE);
    expectOut("bubble", 32'd0, 4'd0, 1'b1, 4'b0000);
    step();
    setWb(1'b1, 4'd3, 32'd12);
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'd5, 32'(FUNCT_SUB), 4'd3, 4'd1, 4'd4, CTL_R);
    expectOut("fwd_memwb", 32'd7, 4'd4, 1'b0, 4'b0001);
    step();
    setWb(1'b1, 4'd0, 32'd99);
    applyStimulus(ALUOP_RTYPE, 32'd20, 32'd5, 32'(FUNCT_ADD), 4'd0, 4'd1, 4'd6, CTL_R);
    expectOut("no_fwd_r0", 32'd25, 4'd6, 1'b0, 4'b0001);
    step();
    setWb(1'b1, 4'd2, 32'd100);
    applyStimulus(ALUOP_RTYPE, 32'd5, 32'd0, 32'(FUNCT_ADD), 4'd1, 4'd2, 4'd7, CTL_R);
    expectOut("fwd_wb_rt", 32'd105, 4'd7, 1'b0, 4'b0001);
    step();
    checkEq("fwd_wb_rt.wdata", ex_mem_wdata, 32'd100);
    setWb(1'b0, 4'd0, 32'd0);

    applyStimulus(ALUOP_SUB, 32'd9, 32'd9, 32'd0, 4'd8, 4'd9, 4'd0, CTL_NONE);
    expectOut("beq", 32'd0, 4'd0, 1'b1, 4'b0000);
    step();
    applyStimulus(ALUOP_ADD, 32'h100, 32'd0, 32'hFFFF_FFFC, 4'd1, 4'd6, 4'd9, CTL_LW);
    expectOut("lw_addr", 32'h0000_00FC, 4'd6, 1'b0, 4'b1101);
    step();
    applyStimulus(ALUOP_RTYPE, 32'd50, 32'd0, 32'(FUNCT_ADD), 4'd6, 4'd0, 4'd8, CTL_R);
    expectOut("no_fwd_load", 32'd50, 4'd8, 1'b0, 4'b0001);
    step();
    applyStimulus(ALUOP_OR, 32'h0F0, 32'd0, 32'h00F, 4'd1, 4'd9, 4'd0, CTL_IMM);
    expectOut("ori", 32'h0FF, 4'd9, 1'b0, 4'b0001);
    step();
    applyStimulus(ALUOP_RTYPE, 32'hFFFF_FFFF, 32'd1, 32'(FUNCT_SLT), 4'd1, 4'd2, 4'd10, CTL_R);
    expectOut("slt_signed", 32'd1, 4'd10, 1'b0, 4'b0001);
    step();
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'h8000_0000, 32'h0000_0102, 4'd0, 4'd2, 4'd11, CTL_R);
    expectOut("srl", 32'h0800_0000, 4'd11, 1'b0, 4'b0001);
    step();
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'h0000_0003, 32'h0000_0100, 4'd0, 4'd2, 4'd11, CTL_R);
    expectOut("sll", 32'h0000_0030, 4'd11, 1'b0, 4'b0001);
    step();
    applyStimulus(ALUOP_RTYPE, 32'hF0F0, 32'h0FF0, 32'(FUNCT_AND), 4'd1, 4'd2, 4'd12, CTL_R);
    expectOut("and", 32'h00F0, 4'd12, 1'b0, 4'b0001);
    step();
    applyStimulus(ALUOP_RTYPE, 32'd3, 32'd4, 32'h0000_003F, 4'd1, 4'd2, 4'd13, CTL_R);
    expectOut("bad_funct", 32'd0, 4'd13, 1'b1, 4'b0001);
    step();

    runMd("multu", 1'b0, 32'hFFFF_FFFF, 32'd2);
    runMd("divu", 1'b1, 32'd100, 32'd7);
    runMd("divu0", 1'b1, 32'h1234, 32'd0);

    applyStimulus(ALUOP_RTYPE, 32'h1234_5678, 32'h9ABC, 32'(FUNCT_MULTU), 4'd1, 4'd2, 4'd0, CTL_R);
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkEq("rst_mid.stall", 32'(ex_stall), 32'd0);
    checkEq("rst_mid.out", ex_mem_alu_result | 32'({ex_mem_rd, ex_mem_zero, ex_mem_memread,
            ex_mem_memtoreg, ex_mem_memwrite, ex_mem_regwrite}), 32'd0);
    applyStimulus(ALUOP_ADD, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, CTL_NONE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'd0, 32'(FUNCT_MFHI), 4'd0, 4'd0, 4'd14, CTL_R);
    expectOut("rst_mid.hi", 32'd0, 4'd14, 1'b1, 4'b0001);
    step();
    applyStimulus(ALUOP_RTYPE, 32'd0, 32'd0, 32'(FUNCT_MFLO), 4'd0, 4'd0, 4'd15, CTL_R);
    expectOut("rst_mid.lo", 32'd0, 4'd15, 1'b1, 4'b0001);
    step();
    runMd("multu_after_rst", 1'b0, 32'h1234_5678, 32'h9ABC);

    checkEq("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
